// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Input is double-synchronised and sampled mid-bit; valid/error are one-cycle pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_EN    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       error,
   output logic       RX_active
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t        state_q;
   logic          rx_meta_q;
   logic          rx_s_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          par_q;
   logic          valid_q;
   logic          error_q;
   logic          active_q;
   logic [7:0]    shift_d;
   logic          par_fail_d;
   logic          cnt_done_d;

   function automatic logic even_parity_fail(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Mid-bit sample helpers: shifted byte, end of bit period, parity verdict.
   always_comb begin
      shift_d    = {rx_s_q, shift_q[7:1]};
      cnt_done_d = (cnt_q == BIT_LAST);
      if (PARITY_EN != 0) begin
         par_fail_d = even_parity_fail(shift_q, par_q);
      end else begin
         par_fail_d = 1'b0;
      end
   end

   // Two-flop synchroniser; resets to the idle line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_serial;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Frame FSM with registered data, pulse and activity outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         par_q     <= 1'b0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               bit_idx_q <= 3'd0;
               if (!rx_s_q) begin
                  state_q  <= START;
                  active_q <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q  <= IDLE;
                     active_q <= 1'b0;
                  end else begin
                     state_q <= DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_done_d) begin
                  cnt_q     <= '0;
                  shift_q   <= shift_d;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        state_q <= PARITY;
                     end else begin
                        state_q <= STOP;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            PARITY: begin
               if (cnt_done_d) begin
                  cnt_q   <= '0;
                  par_q   <= rx_s_q;
                  state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_done_d) begin
                  cnt_q    <= '0;
                  active_q <= 1'b0;
                  // A low stop bit wins over a parity failure: single error, then wait out the break.
                  if (!rx_s_q) begin
                     error_q <= 1'b1;
                     state_q <= BREAK;
                  end else if (par_fail_d) begin
                     error_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     valid_q <= 1'b1;
                     data_q  <= shift_q;
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            BREAK: begin
               if (rx_s_q) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= BREAK;
               end
            end
            default: begin
               state_q  <= IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign error     = error_q;
   assign RX_active = active_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timeline model (expected pulse/activity cycles per frame)
// compared every cycle, plus literal latency and data checks on directed scenarios.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int CPB  = 8;
   localparam int NCYC = 20000;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx   [2];
   logic [7:0] dout [2];
   logic       vld  [2];
   logic       err  [2];
   logic       act  [2];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   int last_k   = 0;

   bit       ev_valid [2][NCYC];
   bit       ev_error [2][NCYC];
   bit       ev_act   [2][NCYC];
   bit [7:0] ev_byte  [2][NCYC];
   logic [7:0] mdata [2];
   int n_valid [2];
   int n_error [2];
   int last_vcyc [2];
   logic [7:0] obs_q [$];

   uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
      .clk(clk), .reset(reset), .rx_serial(rx[0]), .data_out(dout[0]),
      .valid(vld[0]), .error(err[0]), .RX_active(act[0]));

   uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut_np (
      .clk(clk), .reset(reset), .rx_serial(rx[1]), .data_out(dout[1]),
      .valid(vld[1]), .error(err[1]), .RX_active(act[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         failures++;
         $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", name, i, cyc, got, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int i, input logic v, input int n);
      rx[i] = v;
      tick(n);
   endtask

   // Frame whose start bit hits the pin in cycle k: rx_s falls at k+2, sample points follow.
   task automatic schedule(input int i, input int k, input logic [7:0] b, input bit par_bad, input bit stop_ok);
      int t0 = k + 2;
      int ts = t0 + CPB / 2 + ((i == 0) ? 10 : 9) * CPB;
      for (int c = t0 + 1; c <= ts; c++) ev_act[i][c] = 1'b1;
      if (stop_ok && !par_bad) begin
         ev_valid[i][ts + 1] = 1'b1;
         ev_byte[i][ts + 1]  = b;
      end else begin
         ev_error[i][ts + 1] = 1'b1;
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = 0; i < 2; i++) begin
         for (int j = c; j < NCYC; j++) begin
            ev_valid[i][j] = 1'b0;
            ev_error[i][j] = 1'b0;
            ev_act[i][j]   = 1'b0;
         end
      end
   endtask

   task automatic send_frame(input int i, input logic [7:0] b, input bit par_bad, input bit stop_ok, input int stop_len);
      last_k = cyc;
      schedule(i, cyc, b, par_bad, stop_ok);
      drive(i, 1'b0, CPB);
      for (int j = 0; j < 8; j++) drive(i, b[j], CPB);
      if (i == 0) drive(i, (^b) ^ par_bad, CPB);
      drive(i, stop_ok, stop_len);
   endtask

   task automatic glitch(input int i, input int g);
      int t0 = cyc + 2;
      for (int c = t0 + 1; c <= t0 + CPB / 2; c++) ev_act[i][c] = 1'b1;
      drive(i, 1'b0, g);
      drive(i, 1'b1, CPB);
   endtask

   // Per-cycle comparison of both instances against the frame timeline.
   always @(negedge clk) begin
      if (cyc < NCYC) begin
         for (int i = 0; i < 2; i++) begin
            if (reset) mdata[i] = 8'h00;
            else if (ev_valid[i][cyc]) mdata[i] = ev_byte[i][cyc];
            chk("valid", i, 32'(vld[i]), 32'(!reset && ev_valid[i][cyc]));
            chk("error", i, 32'(err[i]), 32'(!reset && ev_error[i][cyc]));
            chk("rx_active", i, 32'(act[i]), 32'(!reset && ev_act[i][cyc]));
            chk("data_out", i, 32'(dout[i]), 32'(mdata[i]));
            if (vld[i] === 1'b1) begin
               n_valid[i]++;
               last_vcyc[i] = cyc;
               if (i == 0) obs_q.push_back(dout[0]);
            end
            if (err[i] === 1'b1) n_error[i]++;
         end
      end
   end

   initial begin
      while (cyc < NCYC - 2) @(posedge clk);
      failures++;
      $display("FAIL watchdog cyc=%0d got=timeout expected=end_of_stimulus", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int         inst;
      int         kind;
      logic [7:0] b;
      reset = 1'b1;
      rx[0] = 1'b1;
      rx[1] = 1'b1;
      tick(3);
      chk("rst_valid", 0, 32'(vld[0]), 32'd0);
      chk("rst_error", 0, 32'(err[0]), 32'd0);
      chk("rst_active", 0, 32'(act[0]), 32'd0);
      chk("rst_data", 0, 32'(dout[0]), 32'd0);
      reset = 1'b0;
      tick(5);

      // 0xAC with a flipped parity bit: one error, data_out stays 0x00.
      send_frame(0, 8'hAC, 1'b1, 1'b1, CPB);
      tick(CPB);
      chk("par_err_count", 0, 32'(n_error[0]), 32'd1);
      chk("par_valid_count", 0, 32'(n_valid[0]), 32'd0);
      chk("par_data", 0, 32'(dout[0]), 32'h00);

      // Good 0xAC: valid 2+4+80+1 cycles after the pin start edge.
      send_frame(0, 8'hAC, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("good_lat", 0, 32'(last_vcyc[0]), 32'(last_k + 87));
      chk("good_data", 0, 32'(dout[0]), 32'hAC);
      chk("good_model", 0, 32'(mdata[0]), 32'hAC);

      // 0x55 with low stop, line held low 30 bit-times, then 0x3C.
      send_frame(0, 8'h55, 1'b0, 1'b0, 30 * CPB);
      drive(0, 1'b1, 2 * CPB);
      chk("break_err_count", 0, 32'(n_error[0]), 32'd2);
      send_frame(0, 8'h3C, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("break_valid_count", 0, 32'(n_valid[0]), 32'd2);
      chk("break_next_data", 0, 32'(dout[0]), 32'h3C);

      glitch(0, 3);
      chk("glitch_valid", 0, 32'(n_valid[0]), 32'd2);
      chk("glitch_error", 0, 32'(n_error[0]), 32'd2);

      // Back-to-back frames with no idle gap.
      send_frame(0, 8'h01, 1'b0, 1'b1, CPB);
      send_frame(0, 8'hFF, 1'b0, 1'b1, CPB);
      send_frame(0, 8'h80, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("b2b_count", 0, 32'(n_valid[0]), 32'd5);
      chk("b2b_byte0", 0, 32'(obs_q[2]), 32'h01);
      chk("b2b_byte1", 0, 32'(obs_q[3]), 32'hFF);
      chk("b2b_byte2", 0, 32'(obs_q[4]), 32'h80);

      // Reset in the middle of D4, then resend.
      b = 8'hAC;
      schedule(0, cyc, b, 1'b0, 1'b1);
      drive(0, 1'b0, CPB);
      for (int j = 0; j < 4; j++) drive(0, b[j], CPB);
      drive(0, b[4], 3);
      reset = 1'b1;
      rx[0] = 1'b1;
      clear_from(cyc);
      tick(3);
      reset = 1'b0;
      tick(2 * CPB);
      chk("abort_count", 0, 32'(n_valid[0] + n_error[0]), 32'd7);
      send_frame(0, 8'hAC, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("resend_data", 0, 32'(dout[0]), 32'hAC);
      chk("resend_count", 0, 32'(n_valid[0]), 32'd6);

      // Line low across reset release: start seen only once the synchroniser shows it.
      reset = 1'b1;
      rx[0] = 1'b0;
      tick(3);
      reset = 1'b0;
      send_frame(0, 8'h96, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("rel_low_lat", 0, 32'(last_vcyc[0]), 32'(last_k + 87));
      chk("rel_low_data", 0, 32'(dout[0]), 32'h96);

      // No-parity instance: valid 2+4+72+1 cycles after the pin start edge.
      send_frame(1, 8'hAC, 1'b0, 1'b1, CPB);
      tick(CPB);
      chk("np_lat", 1, 32'(last_vcyc[1]), 32'(last_k + 79));
      chk("np_data", 1, 32'(dout[1]), 32'hAC);

      for (int n = 0; n < 40; n++) begin
         inst = ((n % 4) == 3) ? 1 : 0;
         kind = $urandom_range(0, 9);
         b    = 8'($urandom);
         if (kind == 0) begin
            glitch(inst, $urandom_range(1, CPB / 2 - 1));
         end else if (kind == 1) begin
            send_frame(inst, b, 1'b0, 1'b0, $urandom_range(CPB, 4 * CPB));
            drive(inst, 1'b1, $urandom_range(1, CPB));
         end else if (kind == 2 && inst == 0) begin
            send_frame(inst, b, 1'b1, 1'b1, $urandom_range(CPB / 2 + 1, CPB));
         end else begin
            send_frame(inst, b, 1'b0, 1'b1, $urandom_range(CPB / 2 + 1, CPB));
         end
         if ($urandom_range(0, 1) == 1) drive(inst, 1'b1, $urandom_range(1, 2 * CPB));
      end
      tick(12 * CPB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
